serial_flow_accum: RTL and testbench
====================================

Name: serial_flow_accum

Overview:
Parametrised successor of the two-line serial flow FSM. Samples LINES serial input lines per clock and accumulates the number of asserted lines into a CNT_W-bit state counter. The counter wraps, saturates, holds or clears under a run-time mode. The block emits a registered data bit, an overflow pulse and a sticky overflow-event count. It sits in the benchmark suite as a scalable sequential DUT for concolic and RL-driven coverage runs.

Parameters:
LINES, 2, number of serial input lines; legal range 1 .. 2**CNT_W-1
CNT_W, 3, width of the accumulator state register
OVF_W, 4, width of the saturating overflow-event counter

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
en  input  1  sample enable; 0 freezes all state
mode  input  2  00 wrap-add, 01 saturate-add, 10 hold, 11 clear
line  input  LINES  serial input lines, sampled on posedge when en=1
outp  output  1  registered data bit
overflw  output  1  registered one-cycle overflow/clip pulse
count  output  CNT_W  accumulator state
ovf_cnt  output  OVF_W  saturating number of overflow events

Behaviour:
- Reset: all registers cleared on posedge clock with reset=1 (count=0, outp=0, overflw=0, ovf_cnt=0). Reset has priority over en and mode. Reset asserted mid-operation discards that cycle's sample.
- All outputs are registered. The effect of a sample is visible one cycle after the sampling edge. No combinational input-to-output path.
- k = popcount(line), computed in clog2(LINES+1) bits. sum = count + k, computed in CNT_W+1 bits; the LINES range guarantees no loss.
- en=0: count, outp and ovf_cnt hold; overflw is forced to 0 next cycle.
- en=1, mode 00 (wrap):
  - count <= sum[CNT_W-1:0].
  - overflw <= sum[CNT_W].
- en=1, mode 01 (saturate):
  - count <= min(sum, 2**CNT_W-1).
  - overflw <= 1 iff sum > 2**CNT_W-1.
  - Sitting at max with k=0 is not an overflow.
- en=1, mode 10 (hold): count holds; overflw <= 0; outp still updates.
- en=1, mode 11 (clear): count <= 0, ovf_cnt <= 0, overflw <= 0, outp <= 0.
- outp, for en=1 and mode != 11: outp <= (^line) XOR count[0], using the pre-update count.
- ovf_cnt increments by 1 on each cycle in which overflw is being set to 1. It saturates at 2**OVF_W-1 and never wraps.
- No illegal states: every count encoding is reachable and legal. mode is decoded fully.
- k=0 in the add modes: count unchanged, overflw=0, outp = count[0].

Test Plan (LINES=2, CNT_W=3, OVF_W=4):
1. Reset: hold reset=1 two cycles with en=1, line=11, mode=00 -> count=0, outp=0, overflw=0, ovf_cnt=0.
2. Wrap: mode=00, en=1, line=11 for 4 cycles -> count 2,4,6,0; overflw=1 only after the 4th edge; ovf_cnt=1.
3. Saturate: from count=6, mode=01, line=11 -> count=7, overflw=1. Then line=01 -> count=7, overflw=1, ovf_cnt +2 total. Then line=00 -> count=7, overflw=0.
4. outp: count=0, mode=00, line=01 -> outp=1, count=1. Next line=11 -> outp=(0 XOR 1)=1, count=3. Next line=10 -> outp=(1 XOR 1)=0, count=4.
5. Hold/enable/clear:
   - en=0 with line=11 for 3 cycles -> count and ovf_cnt unchanged, overflw=0.
   - mode=10, line=01 -> count unchanged, outp toggles per rule.
   - mode=11 -> count=0, ovf_cnt=0 next cycle.
6. Overflow saturation and mid-run reset:
   - mode=01, line=11 held 20 cycles from count=0 -> ovf_cnt stops at 15.
   - reset=1 for one cycle during streaming -> all outputs 0 next cycle; accumulation resumes from 0 after release.

Source files
------------

// File: rtl/serial_flow_accum.sv
// Purpose : counts the asserted serial lines each enabled cycle into a counter that can wrap, saturate, hold or clear; also emits a data bit, an overflow pulse and a count of overflow events.
// Latency : every output is registered and shows a sample's effect one cycle after the edge that sampled it.
// Backpressure: none; en=0 freezes all state and forces the overflow pulse low.
//
// Ports:
//   clock   - system clock; all state updates on its rising edge
//   reset   - synchronous, active-high; clears every register and wins over en and mode
//   en      - sample enable
//   mode    - 00 wrap-add, 01 saturate-add, 10 hold, 11 clear
//   line    - LINES serial input lines
//   outp    - registered data bit: (^line) XOR count[0], taken before count updates
//   overflw - registered one-cycle pulse on a wrap carry or a saturation clip
//   count   - accumulator state
//   ovf_cnt - number of overflow events, saturating at its maximum value
module serial_flow_accum #(
  parameter int LINES = 2,
  parameter int CNT_W = 3,
  parameter int OVF_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [LINES-1:0] line,
  output logic             outp,
  output logic             overflw,
  output logic [CNT_W-1:0] count,
  output logic [OVF_W-1:0] ovf_cnt
);

  // LINES is at most 2**CNT_W-1, so K_W never exceeds CNT_W.
  localparam int K_W = $clog2(LINES + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [OVF_W-1:0] OVF_MAX = {OVF_W{1'b1}};

  typedef enum logic [1:0] {
    MODE_WRAP  = 2'b00,
    MODE_SAT   = 2'b01,
    MODE_HOLD  = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  // Number of asserted lines in the current sample.
  function automatic logic [K_W-1:0] popcount(input logic [LINES-1:0] v);
    logic [K_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < LINES; i++) begin
      acc = acc + K_W'(v[i]);
    end
    return acc;
  endfunction

  logic [K_W-1:0]   k;
  logic [CNT_W:0]   sum;
  logic             line_par;

  logic [CNT_W-1:0] count_nxt;
  logic             outp_nxt;
  logic             ovf_nxt;
  logic [OVF_W-1:0] ovf_cnt_nxt;

  assign k        = popcount(line);
  // The extra carry bit holds the largest possible sum (2*(2**CNT_W-1)) exactly.
  assign sum      = {1'b0, count} + (CNT_W + 1)'(k);
  assign line_par = ^line;

  always_comb begin
    count_nxt   = count;
    outp_nxt    = outp;
    ovf_nxt     = 1'b0;
    ovf_cnt_nxt = ovf_cnt;

    if (en) begin
      unique case (mode_e'(mode))
        MODE_WRAP: begin
          count_nxt = sum[CNT_W-1:0];
          ovf_nxt   = sum[CNT_W];
          outp_nxt  = line_par ^ count[0];
        end
        MODE_SAT: begin
          // Clip only when the sum really exceeds max; holding at max with k=0 is not a clip.
          if (sum[CNT_W]) begin
            count_nxt = CNT_MAX;
            ovf_nxt   = 1'b1;
          end else begin
            count_nxt = sum[CNT_W-1:0];
          end
          outp_nxt = line_par ^ count[0];
        end
        MODE_HOLD: begin
          outp_nxt = line_par ^ count[0];
        end
        MODE_CLEAR: begin
          count_nxt   = '0;
          outp_nxt    = 1'b0;
          ovf_cnt_nxt = '0;
        end
        default: begin
          count_nxt = count;
        end
      endcase

      // The event counter sticks at its maximum value instead of wrapping.
      if (ovf_nxt && (ovf_cnt != OVF_MAX)) begin
        ovf_cnt_nxt = ovf_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= '0;
      outp    <= 1'b0;
      overflw <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      count   <= count_nxt;
      outp    <= outp_nxt;
      overflw <= ovf_nxt;
      ovf_cnt <= ovf_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_serial_flow_accum.sv
module tb_serial_flow_accum;

  localparam int LINES = 2;
  localparam int CNT_W = 3;
  localparam int OVF_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int OMAX  = (1 << OVF_W) - 1;

  logic             clock;
  logic             reset;
  logic             en;
  logic [1:0]       mode;
  logic [LINES-1:0] line;
  logic             outp;
  logic             overflw;
  logic [CNT_W-1:0] count;
  logic [OVF_W-1:0] ovf_cnt;

  serial_flow_accum #(.LINES(LINES), .CNT_W(CNT_W), .OVF_W(OVF_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .line    (line),
    .outp    (outp),
    .overflw (overflw),
    .count   (count),
    .ovf_cnt (ovf_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int cnt;
    int outp;
    int ovf;
    int ovfc;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference state, kept as plain integers.
  int m_cnt  = 0;
  int m_outp = 0;
  int m_ovf  = 0;
  int m_ovfc = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit e, input int m, input int l);
    int ones;
    int par;
    int s;
    ones = 0;
    for (int i = 0; i < LINES; i++) ones += (l >> i) & 1;
    par = ones % 2;
    s   = m_cnt + ones;
    if (r) begin
      m_cnt = 0; m_outp = 0; m_ovf = 0; m_ovfc = 0;
    end else if (!e) begin
      m_ovf = 0;
    end else begin
      case (m)
        0: begin
          m_outp = par ^ (m_cnt % 2);
          m_ovf  = (s > CMAX) ? 1 : 0;
          m_cnt  = s % (CMAX + 1);
        end
        1: begin
          m_outp = par ^ (m_cnt % 2);
          m_ovf  = (s > CMAX) ? 1 : 0;
          m_cnt  = (s > CMAX) ? CMAX : s;
        end
        2: begin
          m_outp = par ^ (m_cnt % 2);
          m_ovf  = 0;
        end
        default: begin
          m_cnt = 0; m_outp = 0; m_ovf = 0; m_ovfc = 0;
        end
      endcase
      if (m_ovf == 1 && m_ovfc < OMAX) m_ovfc++;
    end
  endtask

  // Drive one cycle, push the expected outputs, then compare after the edge.
  task automatic step(input bit r, input bit e, input int m, input int l, input string tag);
    exp_t x;
    reset = r;
    en    = e;
    mode  = 2'(m);
    line  = LINES'(l);
    model(r, e, m, l);
    x.cnt = m_cnt; x.outp = m_outp; x.ovf = m_ovf; x.ovfc = m_ovfc;
    q.push_back(x);
    @(posedge clock);
    #1;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      x = q.pop_front();
      check({tag, "_count"},   int'(count),   x.cnt);
      check({tag, "_outp"},    int'(outp),    x.outp);
      check({tag, "_overflw"}, int'(overflw), x.ovf);
      check({tag, "_ovf_cnt"}, int'(ovf_cnt), x.ovfc);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; mode = 2'b00; line = '1;
    @(negedge clock);

    // 1. Reset held two cycles with live inputs.
    step(1, 1, 0, 3, "reset0");
    step(1, 1, 0, 3, "reset1");
    check("plan_reset_count", int'(count), 0);

    // 2. Wrap: 2,4,6,0 with carry on the 4th edge.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 3, "wrap");
    check("plan_wrap_count", int'(count), 0);
    check("plan_wrap_ovf", int'(overflw), 1);
    check("plan_wrap_ovfcnt", int'(ovf_cnt), 1);

    // 3. Saturate from 6.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 3, "to6");
    step(0, 1, 1, 3, "sat11");
    check("plan_sat_clip", int'(overflw), 1);
    step(0, 1, 1, 1, "sat01");
    check("plan_sat_count", int'(count), CMAX);
    check("plan_sat_ovfcnt", int'(ovf_cnt), 3);
    step(0, 1, 1, 0, "sat00");
    check("plan_sat_atmax_noovf", int'(overflw), 0);

    // 4. outp rule from a cleared counter.
    step(0, 1, 3, 3, "clr");
    step(0, 1, 0, 1, "outp_a");
    check("plan_outp_a", int'(outp), 1);
    step(0, 1, 0, 3, "outp_b");
    check("plan_outp_b", int'(outp), 1);
    step(0, 1, 0, 2, "outp_c");
    check("plan_outp_c", int'(outp), 0);
    check("plan_outp_count", int'(count), 4);

    // 5. Enable low, hold, clear.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 3, "en_off");
    check("plan_enoff_count", int'(count), 4);
    step(0, 1, 2, 1, "hold_a");
    step(0, 1, 2, 1, "hold_b");
    check("plan_hold_count", int'(count), 4);
    step(0, 1, 0, 3, "pre_clr");
    step(0, 1, 3, 3, "clear");
    check("plan_clear_ovfcnt", int'(ovf_cnt), 0);

    // 6. Event counter saturation, then reset mid-stream.
    for (int i = 0; i < 20; i++) step(0, 1, 1, 3, "ovf_sat");
    check("plan_ovfcnt_max", int'(ovf_cnt), OMAX);
    step(0, 1, 3, 0, "clr2");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, "stream");
    step(1, 1, 0, 1, "midreset");
    step(0, 1, 0, 1, "resume");
    check("plan_resume_count", int'(count), 1);

    // Random mix, rare resets.
    for (int i = 0; i < 80; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
